// File: rtl/sdr_pkg.sv
// Shared sizing helpers for the SDR datapath: product, accumulator and log2 widths.
// Latency: none (compile-time constant functions only).
// Backpressure: not applicable.
package sdr_pkg;

   // Ceiling log2; the result is exact for power-of-two decimation lengths
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = 1; v < value; v = v * 2) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Full-precision width of an ADC sample times an NCO sample
   function automatic int prod_w(input int adc_w, input int data_w);
      return adc_w + data_w;
   endfunction

   // Accumulator width that holds DECIMATION worst-case products without overflow
   function automatic int acc_w(input int adc_w, input int data_w, input int dec);
      return prod_w(adc_w, data_w) + clog2(dec);
   endfunction

endpackage

// File: rtl/iq_downconverter_integrate_dump.sv
// Integrate-and-dump for one rail (I or Q): accumulates products, publishes the scaled window total.
// Latency: result registered on the dump cycle (same edge that consumes the last product).
// Backpressure: none; a product is consumed on every prod_valid cycle. Rounding via IQ_DOWNCONVERTER_ROUND_EN.
module integrate_dump #(
   parameter int PROD_W    = 19,
   parameter int ACC_W     = 21,
   parameter int OUT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        arst,
   input  logic                        restart,
   input  logic                        prod_valid,
   input  logic                        dump,
   input  logic signed [PROD_W-1:0]    prod,
   output logic signed [OUT_WIDTH-1:0] result
);

   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     sum;
   logic signed [OUT_WIDTH-1:0] scaled;

   // The dump value includes the product arriving on the dump cycle itself
   assign sum = acc + ACC_W'(prod);

   generate
      if (OUT_WIDTH >= ACC_W) begin : g_extend
         // Output is wide enough for the whole sum: sign-extend, no rounding needed
         assign scaled = OUT_WIDTH'(sum);
      end else begin : g_slice
         localparam int SHIFT = ACC_W - OUT_WIDTH;
         logic signed [ACC_W-1:0] adj;
`ifdef IQ_DOWNCONVERTER_ROUND_EN
         // Round half up: add half an output LSB before dropping the low bits
         localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (SHIFT - 1);
         assign adj = sum + HALF;
`else
         // Plain truncation (floor) of the discarded LSBs
         assign adj = sum;
`endif
         assign scaled = OUT_WIDTH'(adj >>> SHIFT);
      end
   endgenerate

   // Accumulate each product; on dump publish the total and open a fresh window
   always_ff @(posedge clk) begin
      if (arst) begin
         acc    <= '0;
         result <= '0;
      end else if (restart) begin
         acc <= '0;
      end else if (prod_valid) begin
         if (dump) begin
            result <= scaled;
            acc    <= '0;
         end else begin
            acc <= sum;
         end
      end
   end

endmodule

// File: rtl/iq_downconverter.sv
// IQ downconverter: mixes ADC samples with NCO sin/cos, integrates DECIMATION products per output.
// Latency: out_valid 2 cycles after the ce carrying the last sample of a window.
// Backpressure: none; accepts a sample every cycle. Optional rounding via IQ_DOWNCONVERTER_ROUND_EN.
module iq_downconverter
   import sdr_pkg::*;
#(
   parameter int DATA_WIDTH = 7,
   parameter int ADC_WIDTH  = 12,
   parameter int DECIMATION = 16,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic                         sample_clk_ce,
   input  logic                         restart,
   input  logic signed [ADC_WIDTH-1:0]  adc_sample,
   input  logic signed [DATA_WIDTH-1:0] sinewave,
   input  logic signed [DATA_WIDTH-1:0] cosinewave,
   output logic signed [OUT_WIDTH-1:0]  i_out,
   output logic signed [OUT_WIDTH-1:0]  q_out,
   output logic                         out_valid
);

   localparam int PROD_W = prod_w(ADC_WIDTH, DATA_WIDTH);
   localparam int ACC_W  = acc_w(ADC_WIDTH, DATA_WIDTH, DECIMATION);
   localparam int CNT_W  = clog2(DECIMATION);

   logic signed [PROD_W-1:0] i_mult;
   logic signed [PROD_W-1:0] q_mult;
   logic signed [PROD_W-1:0] i_prod;
   logic signed [PROD_W-1:0] q_prod;
   logic                     prod_valid;
   logic [CNT_W-1:0]         count;
   logic                     dump;

   // Full-precision mixing; Q uses the negated sine so the result is a true complex downconversion
   assign i_mult = PROD_W'(adc_sample) * PROD_W'(cosinewave);
   assign q_mult = -(PROD_W'(adc_sample) * PROD_W'(sinewave));

   assign dump = prod_valid && (count == CNT_W'(DECIMATION - 1));

   // Product pipeline stage; restart drops both the in-flight product and any new sample
   always_ff @(posedge clk) begin
      if (arst) begin
         i_prod     <= '0;
         q_prod     <= '0;
         prod_valid <= 1'b0;
      end else if (restart) begin
         prod_valid <= 1'b0;
      end else begin
         prod_valid <= sample_clk_ce;
         if (sample_clk_ce) begin
            i_prod <= i_mult;
            q_prod <= q_mult;
         end
      end
   end

   // Window position counter and output strobe shared by both rails
   always_ff @(posedge clk) begin
      if (arst || restart) begin
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= dump;
         if (prod_valid) begin
            count <= dump ? '0 : count + 1'b1;
         end
      end
   end

   integrate_dump #(
      .PROD_W    (PROD_W),
      .ACC_W     (ACC_W),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_i_rail (
      .clk        (clk),
      .arst       (arst),
      .restart    (restart),
      .prod_valid (prod_valid),
      .dump       (dump),
      .prod       (i_prod),
      .result     (i_out)
   );

   integrate_dump #(
      .PROD_W    (PROD_W),
      .ACC_W     (ACC_W),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_q_rail (
      .clk        (clk),
      .arst       (arst),
      .restart    (restart),
      .prod_valid (prod_valid),
      .dump       (dump),
      .prod       (q_prod),
      .result     (q_out)
   );

endmodule

// File: tb/tb_iq_downconverter.sv
// Bench for iq_downconverter: two instances (OUT_WIDTH 21 and 16) driven in parallel, DECIMATION=4.
// A window-level reference model checks every cycle; tables and directed sequences add fixed values.
// Rounding expectations follow IQ_DOWNCONVERTER_ROUND_EN when it is defined for the whole build.
module tb_iq_downconverter;

   localparam int DEC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               arst;
   logic               restart;
   logic               sample_clk_ce;
   logic signed [11:0] adc_sample;
   logic signed [6:0]  sinewave;
   logic signed [6:0]  cosinewave;
   logic signed [20:0] i21, q21;
   logic signed [15:0] i16, q16;
   logic               v21, v16;

   iq_downconverter #(.DATA_WIDTH(7), .ADC_WIDTH(12), .DECIMATION(DEC), .OUT_WIDTH(21)) dut21 (
      .clk(clk), .arst(arst), .sample_clk_ce(sample_clk_ce), .restart(restart),
      .adc_sample(adc_sample), .sinewave(sinewave), .cosinewave(cosinewave),
      .i_out(i21), .q_out(q21), .out_valid(v21));

   iq_downconverter #(.DATA_WIDTH(7), .ADC_WIDTH(12), .DECIMATION(DEC), .OUT_WIDTH(16)) dut16 (
      .clk(clk), .arst(arst), .sample_clk_ce(sample_clk_ce), .restart(restart),
      .adc_sample(adc_sample), .sinewave(sinewave), .cosinewave(cosinewave),
      .i_out(i16), .q_out(q16), .out_valid(v16));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int strobes  = 0;
   int strobe_cyc[$];

   // Reference model: a sample joins the window one cycle after its ce unless reset/restart intervenes
   longint win_i, win_q;
   int     win_n;
   bit     pend;
   longint pend_i, pend_q;
   bit     exp_v;
   longint exp_i21, exp_q21, exp_i16, exp_q16;

   function automatic longint scale16(input longint s);
`ifdef IQ_DOWNCONVERTER_ROUND_EN
      return (s + 16) >>> 5;
`else
      return s >>> 5;
`endif
   endfunction

   function automatic void model_step(input bit a, input bit r, input bit ce,
                                      input int adc, input int s, input int c);
      exp_v = 1'b0;
      if (a || r) begin
         win_i = 0; win_q = 0; win_n = 0; pend = 1'b0;
         if (a) begin
            exp_i21 = 0; exp_q21 = 0; exp_i16 = 0; exp_q16 = 0;
         end
      end else begin
         if (pend) begin
            win_i += pend_i;
            win_q += pend_q;
            win_n++;
            if (win_n == DEC) begin
               exp_v   = 1'b1;
               exp_i21 = win_i;
               exp_q21 = win_q;
               exp_i16 = scale16(win_i);
               exp_q16 = scale16(win_q);
               win_i = 0; win_q = 0; win_n = 0;
            end
         end
         pend   = ce;
         pend_i = longint'(adc) * c;
         pend_q = -(longint'(adc) * s);
      end
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, want);
      end
   endtask

   // One clock: drive at negedge, model at the edge, compare at the following negedge
   task automatic cycle(input bit a, input bit r, input bit ce,
                        input int adc, input int s, input int c);
      arst          = a;
      restart       = r;
      sample_clk_ce = ce;
      adc_sample    = 12'(adc);
      sinewave      = 7'(s);
      cosinewave    = 7'(c);
      @(posedge clk);
      model_step(a, r, ce, adc, s, c);
      @(negedge clk);
      cyc++;
      check("out_valid_w21", longint'(v21), longint'(exp_v));
      check("out_valid_w16", longint'(v16), longint'(exp_v));
      check("i_out_w21", i21, exp_i21);
      check("q_out_w21", q21, exp_q21);
      check("i_out_w16", i16, exp_i16);
      check("q_out_w16", q16, exp_q16);
      if (v21) begin
         strobes++;
         strobe_cyc.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
   endtask

   typedef struct {
      int adc; int c; int s;
      int i21; int q21;
      int i16t; int i16r; int q16t; int q16r;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int s0, lat, got;
      longint ci21, cq21, ci16, cq16;

      vecs[0] = '{adc: 100,   c: 63,  s: 0,   i21: 25200,  q21: 0,       i16t: 787,   i16r: 788,   q16t: 0,      q16r: 0};
      vecs[1] = '{adc: -1,    c: 1,   s: 0,   i21: -4,     q21: 0,       i16t: -1,    i16r: 0,     q16t: 0,      q16r: 0};
      vecs[2] = '{adc: 10,    c: 1,   s: -1,  i21: 40,     q21: 40,      i16t: 1,     i16r: 1,     q16t: 1,      q16r: 1};
      vecs[3] = '{adc: -2048, c: -64, s: -64, i21: 524288, q21: -524288, i16t: 16384, i16r: 16384, q16t: -16384, q16r: -16384};
      vecs[4] = '{adc: 2047,  c: 63,  s: 63,  i21: 515844, q21: -515844, i16t: 16120, i16r: 16120, q16t: -16121, q16r: -16120};

      win_i = 0; win_q = 0; win_n = 0; pend = 1'b0; pend_i = 0; pend_q = 0;
      exp_v = 1'b0; exp_i21 = 0; exp_q21 = 0; exp_i16 = 0; exp_q16 = 0;

      // Reset state
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
      check("reset_i_out", i21, 0);
      check("reset_out_valid", longint'(v21), 0);

      // Constant-input windows with hand-derived results and strobe latency
      foreach (vecs[v]) begin
         for (int k = 0; k < DEC; k++) cycle(1'b0, 1'b0, 1'b1, vecs[v].adc, vecs[v].s, vecs[v].c);
         got = 0; lat = 0;
         ci21 = 0; cq21 = 0; ci16 = 0; cq16 = 0;
         for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (v21 && got == 0) begin
               got = 1; lat = k + 1;
               ci21 = i21; cq21 = q21; ci16 = i16; cq16 = q16;
            end
         end
         check("vec_latency", got ? lat : -1, 2);
         check("vec_i21", ci21, vecs[v].i21);
         check("vec_q21", cq21, vecs[v].q21);
`ifdef IQ_DOWNCONVERTER_ROUND_EN
         check("vec_i16", ci16, vecs[v].i16r);
         check("vec_q16", cq16, vecs[v].q16r);
`else
         check("vec_i16", ci16, vecs[v].i16t);
         check("vec_q16", cq16, vecs[v].q16t);
`endif
      end

      // Restart after two samples, with a sample presented during restart
      s0 = strobes;
      cycle(1'b0, 1'b0, 1'b1, 500, 5, 7);
      cycle(1'b0, 1'b0, 1'b1, 500, 5, 7);
      cycle(1'b0, 1'b1, 1'b1, 500, 5, 7);
      for (int k = 0; k < DEC; k++) cycle(1'b0, 1'b0, 1'b1, 10, -1, 1);
      idle(6);
      check("restart_strobe_count", strobes - s0, 1);
      check("restart_i_held", i21, 40);
      check("restart_q_held", q21, 40);

      // Reset mid-window: partial window discarded, outputs cleared
      s0 = strobes;
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 10, -1, 1);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
      check("midreset_i_out", i21, 0);
      check("midreset_q_out", q21, 0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 10, -1, 1);
      idle(4);
      check("midreset_no_strobe", strobes - s0, 0);
      cycle(1'b0, 1'b0, 1'b1, 10, -1, 1);
      idle(3);
      check("midreset_fourth_strobe", strobes - s0, 1);
      check("midreset_i_value", i21, 40);

      // Reset and restart together: reset wins and clears outputs
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
      check("reset_priority_i_out", i21, 0);
      check("reset_priority_q_out", q21, 0);

      // Full-rate ce at worst-case magnitude
      s0 = strobes;
      strobe_cyc.delete();
      for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 1'b1, -2048, -64, -64);
      idle(4);
      check("fullrate_strobe_count", strobes - s0, 3);
      for (int k = 1; k < strobe_cyc.size(); k++)
         check("fullrate_spacing", strobe_cyc[k] - strobe_cyc[k-1], 4);
      check("fullrate_i_out", i21, 524288);
      check("fullrate_q_out", q21, -524288);

      // Randomized traffic with occasional restart and reset
      for (int k = 0; k < 600; k++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 7),
               int'($urandom_range(0, 4095)) - 2048,
               int'($urandom_range(0, 127)) - 64,
               int'($urandom_range(0, 127)) - 64);
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
